// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line into the receiver, received byte and status pulses out.
interface uart_receiver_if;
    logic       Rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;
    modport master (input Rx, output data, rx_done, frame_err, parity_err, busy);
    modport slave (output Rx, input data, rx_done, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit LSB-first UART receiver, 2-flop synchronizer, mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart_receiver #(
    parameter int CLOCK_PER_BIT = 868
) (
    input logic            clk,
    input logic            rst,
    uart_receiver_if.master u
);
    localparam logic [15:0] FULL = 16'(CLOCK_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((CLOCK_PER_BIT - 1) / 2);
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
`ifdef UART_RX_PARITY_EN
        RX_PARITY_BIT = 3'd5,
`endif
        RX_START_BIT  = 3'd1,
        RX_DATA_BITS  = 3'd2,
        RX_STOP_BIT   = 3'd3,
        RX_CLEANUP    = 3'd4
    } state_t;
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = RX_PARITY_BIT;
    logic par_bit;
    logic perr;
    assign u.parity_err = perr;
`else
    localparam state_t AFTER_DATA = RX_STOP_BIT;
    assign u.parity_err = 1'b0;
`endif
    state_t      state;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            u.data      <= '0;
            u.rx_done   <= 1'b0;
            u.frame_err <= 1'b0;
            u.busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            perr        <= 1'b0;
`endif
        end else begin
            rx_m        <= u.Rx;
            rx_s        <= rx_m;
            u.rx_done   <= 1'b0;
            u.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state  <= RX_START_BIT;
                        u.busy <= 1'b1;
                    end
                end
                // Line must still be low at mid start bit, otherwise it was a glitch.
                RX_START_BIT:
                    if (cnt == HALF) begin
                        cnt    <= '0;
                        state  <= rx_s ? IDLE : RX_DATA_BITS;
                        u.busy <= !rx_s;
                    end else cnt <= cnt + 16'd1;
                RX_DATA_BITS:
                    if (cnt == FULL) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) state <= AFTER_DATA;
                    end else cnt <= cnt + 16'd1;
`ifdef UART_RX_PARITY_EN
                RX_PARITY_BIT:
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= RX_STOP_BIT;
                    end else cnt <= cnt + 16'd1;
`endif
                RX_STOP_BIT:
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_CLEANUP;
                        if (!rx_s) u.frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        else if (^{shift, par_bit}) perr <= 1'b1;
`endif
                        else begin
                            u.data    <= shift;
                            u.rx_done <= 1'b1;
                        end
                    end else cnt <= cnt + 16'd1;
                // A held-low line (break) must release before a new start can be seen.
                RX_CLEANUP:
                    if (rx_s) begin
                        state  <= IDLE;
                        u.busy <= 1'b0;
                    end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    idx    <= '0;
                    u.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
